// File: rtl/dpmem_arb_pkg.sv
// Types and helpers shared by the dpmem arbiter and its round-robin core.
// Pure declarations: no latency, no flow control.
package dpmem_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // One stage of the in-flight read tracker.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } rd_slot_t;

    // Distance from the priority pointer to requester i, walking upward with wrap.
    function automatic int rr_dist(input int i, input int ptr, input int n);
        int d;
        d = i - ptr;
        if (d < 0) d = d + n;
        return d;
    endfunction

endpackage

// File: rtl/dpmem_arb_defs.vh
// Shared read-latency constant and packed-slice helpers; include inside a module
// body after OUTREG is declared.
`ifndef DPMEM_ARB_DEFS_VH
`define DPMEM_ARB_DEFS_VH
`define DPA_SLICE(idx, w) ((idx)*(w)) +: (w)
`endif

localparam int RD_LAT = 2 + OUTREG;

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a registered pointer.
// Zero latency from req to gnt; grants nothing while srst is high.
module rr_arbiter
    import dpmem_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    int            best;
    int            best_d;
    int            d;
    logic          found;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        best    = 0;
        best_d  = N;
        d       = 0;
        found   = 1'b0;
        // The closest requester at or above the pointer wins.
        for (int i = 0; i < N; i++) begin
            d = rr_dist(i, int'(ptr), N);
            if (req[i] && d < best_d) begin
                best_d = d;
                best   = i;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = found && (best == i);
        end
        if (found) begin
            ptr_nxt = (best == N - 1) ? '0 : PW'(best + 1);
        end
        if (srst) begin
            gnt     = '0;
            ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/dpmem_arb.sv
// Arbitrates NREQ requesters onto one read-first RAM port, one grant per cycle;
// read data returns RD_LAT cycles after grant, responses are never back-pressured.
module dpmem_arb
    import dpmem_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 10,
    parameter int WIDTH  = 32,
    parameter int OUTREG = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*DEPTH-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]      mem_di,
    input  logic [WIDTH-1:0]      mem_do
);

`include "dpmem_arb_defs.vh"

    logic [NREQ-1:0]  gnt;
    logic             any_gnt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_we;
    logic [DEPTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_data;
    rd_slot_t         pipe [RD_LAT];

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk  (clk),
        .srst (srst),
        .req  (req_valid),
        .gnt  (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    // Grant is one-hot, so a priority-free select of the winning slice is safe.
    always_comb begin
        sel_idx  = '0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_idx  = IDX_W'(i);
                sel_we   = req_we[i];
                sel_addr = req_addr[`DPA_SLICE(i, DEPTH)];
                sel_data = req_data[`DPA_SLICE(i, WIDTH)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_di   <= '0;
        end else if (any_gnt) begin
            mem_en   <= 1'b1;
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            mem_di   <= sel_data;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
        end
    end

    // Read tracker: stage 0 is loaded on the grant edge, the last stage lines
    // up with the cycle the RAM presents that read's data on mem_do.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0].vld <= any_gnt && !sel_we;
            pipe[0].idx <= sel_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = pipe[RD_LAT-1].vld && (pipe[RD_LAT-1].idx == IDX_W'(i));
        end
    end

    assign rsp_data = mem_do;

endmodule
